sc_tx_sched: RTL
================

// Module: sc_tx_sched
// PURPOSE
//  Output scheduler between the stream-cipher datapath and the UART transmit buffer.
//  Queues ciphertext bytes (encrypt), plaintext chars (decrypt) and end-of-line events.
//  Expands each queued item into the character sequence the UART must see:
//    - encrypt byte: two uppercase ASCII hex digits.
//    - decrypt char: one char.
//    - end-of-line: CR then LF.
//  Paces all output with a valid/ready handshake, so the datapath never stalls on UART backpressure.
// PARAMETERS
//  DEPTH    4  queue entries (power of 2, >=2)
//  DEPTH_W  2  log2(DEPTH)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous reset, active-low (0 = reset)
//  enc_byte_vld  in   1        1-cycle pulse: enc_byte holds a new ciphertext byte
//  enc_byte      in   8        ciphertext byte (plaintext ^ PRNG byte)
//  dec_char_vld  in   1        1-cycle pulse: dec_char holds a decrypted char
//  dec_char      in   8        decrypted printable char
//  eol           in   1        1-cycle pulse: end of line (CR received)
//  tx_ready      in   1        UART transmit buffer can accept a char this cycle
//  tx_data_rdy   out  1        tx_data valid; held until accepted
//  tx_data       out  8        char to UART
//  busy          out  1        queue non-empty or a sequence in progress
//  ovf           out  1        sticky: an input was dropped
//  count         out  DEPTH_W+1  queued entries, including the one being emitted
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//    - queue empty, FSM=IDLE, count=0.
//    - tx_data_rdy=0, tx_data=8'h00, busy=0, ovf=0.
//    - Reset applies mid-sequence: partial output is abandoned, with no completion.
//  Queue entry: {type[1:0], data[7:0]}.
//    - type: ENC=0, DEC=1, EOL=2.
//    - Entries carry their type, so output never depends on current mode.
//  Push sources, one push per cycle, in priority order:
//    1. eol_pend
//    2. enc_byte_vld
//    3. dec_char_vld
//  Coincident inputs:
//    - eol coincident with a byte valid: the byte is pushed; eol is latched in eol_pend.
//    - eol_pend is pushed in the next cycle.
//    - Any byte valid losing arbitration is dropped and sets ovf.
//    - enc and dec valid together: enc pushed, dec dropped, ovf=1.
//  Full queue:
//    - Push to a full queue with no pop in the same cycle: input dropped, ovf=1, count unchanged.
//    - Push to a full queue with a pop in the same cycle: accepted.
//  Transfer: occurs at a posedge where tx_data_rdy && tx_ready.
//    - tx_data is stable while tx_data_rdy=1 && !tx_ready.
//  FSM states: IDLE, HI, LO, CHR, CR, LF. tx_data is registered and presented with the state.
//    - IDLE: if queue is non-empty, go to head-type state next cycle:
//        ENC->HI, DEC->CHR, EOL->CR.
//    - Latency: push into an empty IDLE queue -> tx_data_rdy=1 two cycles later.
//    - HI: tx_data=hex(data[7:4]). On transfer -> LO.
//    - LO: tx_data=hex(data[3:0]). On transfer -> pop, go to the next entry state.
//    - CHR: tx_data=data. On transfer -> pop.
//    - CR: tx_data=8'h0D. On transfer -> LF.
//    - LF: tx_data=8'h0A. On transfer -> pop.
//    - Back-to-back: at the pop transfer, if another entry is queued, go directly to its state.
//      No IDLE bubble, so tx_data_rdy stays 1.
//  hex(n): n<10 -> 8'h30+n; else 8'h37+n ('A'..'F').
//  Pointers: rd/wr are DEPTH_W bits, wrap modulo DEPTH; count is DEPTH_W+1 bits.
//    - Simultaneous push and pop: count unchanged.
//  busy = (count!=0) | eol_pend.
// TESTING
//  1. enc 8'h3A, tx_ready=1:
//     -> tx_data 8'h33 then 8'h41 on consecutive transfers; busy falls after the second.
//  2. Same as 1 with tx_ready=0 for 5 cycles:
//     -> tx_data_rdy=1, tx_data=8'h33 held stable; resumes in order when tx_ready=1.
//  3. dec 8'h48, then eol:
//     -> 8'h48, 8'h0D, 8'h0A with no idle cycle between chars (tx_ready=1).
//  4. eol in the same cycle as enc 8'hF0:
//     -> 8'h46, 8'h30, 8'h0D, 8'h0A; ovf=0.
//  5. tx_ready=0, 5 enc pushes (DEPTH=4):
//     -> count=4, ovf=1, 5th byte dropped; the 4 bytes drain in push order.
//  6. rst=0 during the LO state with 2 entries queued:
//     -> next cycle tx_data_rdy=0, count=0, busy=0, ovf=0; a subsequent push works normally.

Source files
------------

// File: rtl/sc_tx_if.sv
// sc_tx_if - bundle between the stream-cipher datapath / UART buffer and the
// output scheduler (sc_tx_sched).
//
// Signals
//   enc_byte_vld, enc_byte  new ciphertext byte (1-cycle pulse + data)
//   dec_char_vld, dec_char  new decrypted char (1-cycle pulse + data)
//   eol                     end-of-line pulse
//   tx_ready                UART transmit buffer can take a char this cycle
//   tx_data_rdy, tx_data    char offered to the UART, held until accepted
//   busy                    scheduler has queued or in-flight work
//   ovf                     sticky: an input was dropped
//   count                   queued entries, including the one being emitted
//
// Modports
//   master  datapath/UART side (drives inputs, observes outputs)
//   slave   scheduler side
interface sc_tx_if #(
    parameter int DEPTH_W = 2
);
    logic               enc_byte_vld;
    logic [7:0]         enc_byte;
    logic               dec_char_vld;
    logic [7:0]         dec_char;
    logic               eol;
    logic               tx_ready;
    logic               tx_data_rdy;
    logic [7:0]         tx_data;
    logic               busy;
    logic               ovf;
    logic [DEPTH_W:0]   count;

    modport master (
        output enc_byte_vld, enc_byte, dec_char_vld, dec_char, eol, tx_ready,
        input  tx_data_rdy, tx_data, busy, ovf, count
    );

    modport slave (
        input  enc_byte_vld, enc_byte, dec_char_vld, dec_char, eol, tx_ready,
        output tx_data_rdy, tx_data, busy, ovf, count
    );
endinterface

// File: rtl/sc_tx_sched.sv
// sc_tx_sched - output scheduler between the stream-cipher datapath and the
// UART transmit buffer.
//
// Queues ciphertext bytes, plaintext chars and end-of-line events, then
// expands each entry into the characters the UART must see:
//   encrypt byte -> two uppercase ASCII hex digits
//   decrypt char -> the char itself
//   end-of-line  -> CR, LF
// Output is paced by tx_data_rdy/tx_ready so the datapath never stalls.
//
// Ports
//   clk   system clock
//   rst   synchronous reset, active-low
//   bus   sc_tx_if.slave (inputs: enc/dec/eol pulses, tx_ready;
//         outputs: tx_data_rdy, tx_data, busy, ovf, count)
module sc_tx_sched #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic   clk,
    input  logic   rst,
    sc_tx_if.slave bus
);

    localparam logic [1:0] TYPE_ENC = 2'd0;
    localparam logic [1:0] TYPE_DEC = 2'd1;
    localparam logic [1:0] TYPE_EOL = 2'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_CHR  = 3'd3;
    localparam logic [2:0] S_CR   = 3'd4;
    localparam logic [2:0] S_LF   = 3'd5;

    // Entry layout: {type[1:0], data[7:0]}
    logic [9:0]         mem [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr;
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr_inc;
    logic [DEPTH_W:0]   cnt;
    logic               eol_pend;
    logic               ovf_r;
    logic [2:0]         state;
    logic [7:0]         tx_data_r;

    logic               xfer;
    logic               pop;
    logic               full;
    logic               push_req;
    logic               push;
    logic [9:0]         push_entry;
    logic               eol_pend_nxt;
    logic               drop;
    logic [9:0]         head;
    logic [9:0]         next_head;

    function automatic logic [7:0] hex(input logic [3:0] n);
        hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [2:0] entry_state(input logic [1:0] t);
        case (t)
            TYPE_ENC: entry_state = S_HI;
            TYPE_DEC: entry_state = S_CHR;
            default:  entry_state = S_CR;
        endcase
    endfunction

    function automatic logic [7:0] entry_char(input logic [9:0] e);
        case (e[9:8])
            TYPE_ENC: entry_char = hex(e[7:4]);
            TYPE_DEC: entry_char = e[7:0];
            default:  entry_char = 8'h0D;
        endcase
    endfunction

    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign head       = mem[rd_ptr];
    assign next_head  = mem[rd_ptr_inc];

    assign xfer = (state != S_IDLE) && bus.tx_ready;
    // The last character of an entry releases its queue slot.
    assign pop  = xfer && ((state == S_LO) || (state == S_CHR) || (state == S_LF));
    // DEPTH is a power of two and cnt never exceeds it, so the MSB means full.
    assign full = cnt[DEPTH_W];

    // Push arbitration. A pending EOL wins; a byte coincident with eol wins
    // and parks the eol in eol_pend for the next cycle; a lone eol goes
    // straight in so it can follow a byte already queued without a bubble.
    always_comb begin
        push_req     = 1'b0;
        push_entry   = '0;
        eol_pend_nxt = eol_pend;
        drop         = 1'b0;
        if (eol_pend) begin
            push_req     = 1'b1;
            push_entry   = {TYPE_EOL, 8'h00};
            eol_pend_nxt = bus.eol;
            drop         = bus.enc_byte_vld | bus.dec_char_vld;
        end else if (bus.enc_byte_vld) begin
            push_req     = 1'b1;
            push_entry   = {TYPE_ENC, bus.enc_byte};
            eol_pend_nxt = bus.eol;
            drop         = bus.dec_char_vld;
        end else if (bus.dec_char_vld) begin
            push_req     = 1'b1;
            push_entry   = {TYPE_DEC, bus.dec_char};
            eol_pend_nxt = bus.eol;
        end else if (bus.eol) begin
            push_req     = 1'b1;
            push_entry   = {TYPE_EOL, 8'h00};
        end
        // A same-cycle pop frees the slot, so a full queue can still accept.
        push = push_req && (!full || pop);
        if (push_req && !push) begin
            drop = 1'b1;
        end
    end

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            eol_pend <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            eol_pend <= eol_pend_nxt;
            if (drop) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Output FSM. tx_data is loaded together with the state it belongs to.
    // At a popping transfer the decision uses the pre-push count, so an
    // entry pushed on that same edge is picked up via IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            tx_data_r <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cnt != '0) begin
                        state     <= entry_state(head[9:8]);
                        tx_data_r <= entry_char(head);
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        state     <= S_LO;
                        tx_data_r <= hex(head[3:0]);
                    end
                end
                S_CR: begin
                    if (xfer) begin
                        state     <= S_LF;
                        tx_data_r <= 8'h0A;
                    end
                end
                S_LO, S_CHR, S_LF: begin
                    if (xfer) begin
                        if (cnt > {{DEPTH_W{1'b0}}, 1'b1}) begin
                            state     <= entry_state(next_head[9:8]);
                            tx_data_r <= entry_char(next_head);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data_rdy = (state != S_IDLE);
    assign bus.tx_data     = tx_data_r;
    assign bus.busy        = (cnt != '0) | eol_pend;
    assign bus.ovf         = ovf_r;
    assign bus.count       = cnt;

endmodule
